lz77_token_packer: RTL and testbench
====================================

// Module: lz77_token_packer
// PURPOSE
//  Parametrised successor to the fixed 14-bit LZ77 token register. Accepts
//  (offset, length, next_char) tokens from the match finder over valid/ready.
//  Optional compaction shortens literal tokens (length==0). Packs the token
//  bitstream MSB-first into OUT_W-bit words for the output/storage stage, with
//  backpressure and an explicit flush that zero-pads the final partial word.
// PARAMETERS
//  OFF_W    3   match offset width
//  LEN_W    3   match length width
//  CHR_W    8   literal/next_char width
//  OUT_W    16  packed output word width
//  COMPACT  1   1: flag-prefixed variable-length tokens; 0: fixed TOK_W tokens
//  CNT_W    16  accepted-token counter width
//  Derived: TOK_W=OFF_W+LEN_W+CHR_W; MAX_T=TOK_W+COMPACT; BUF_W=OUT_W+MAX_T
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-high
//  in_valid     in   1      token valid
//  in_ready     out  1      token accepted when in_valid&&in_ready
//  in_offset    in   OFF_W  match offset
//  in_length    in   LEN_W  match length (0 = literal)
//  in_char      in   CHR_W  next character
//  flush        in   1      request drain; sampled only in RUN
//  out_valid    out  1      packed word valid
//  out_ready    in   1      downstream accepts word
//  out_data     out  OUT_W  packed word, oldest bit at MSB
//  out_last     out  1      qualifies final word of a flush
//  flush_done   out  1      one-cycle pulse: flush complete
//  tok_cnt      out  CNT_W  accepted tokens since reset, wraps
// BEHAVIOUR
//  Reset: bit buffer cleared, bit_cnt=0, state RUN; all outputs 0.
//  Encoding, COMPACT=1: len!=0 -> {1'b1,off,len,chr} (MAX_T bits);
//    len==0 -> {1'b0,chr} (1+CHR_W bits), offset ignored.
//  Encoding, COMPACT=0: always {off,len,chr} (TOK_W bits), no flag.
//  Buffer: BUF_W bits, left-aligned, bit_cnt valid bits at the MSB end.
//  in_ready = (state==RUN) && (bit_cnt <= OUT_W). Registered state only; no
//    combinational path from out_ready.
//  out_valid = (bit_cnt >= OUT_W) || (state==FLUSH && bit_cnt != 0).
//  out_data = top OUT_W bits of buffer; missing LSBs are zero in FLUSH.
//  out_data and out_valid hold stable while out_valid && !out_ready.
//  Same-cycle fire of both sides: shift left by OUT_W, then append the token
//    at new bit_cnt. bit_cnt' = bit_cnt - (out fire ? min(OUT_W,bit_cnt) : 0)
//    + (in fire ? tok_bits : 0). Bound: bit_cnt <= BUF_W always.
//  Latency: a token completing a word gives out_valid on the next cycle.
//  FSM RUN -> FLUSH on flush (token accepted in the same cycle is included;
//    in_ready is 0 from the next cycle). FLUSH emits words until bit_cnt==0.
//    out_last=1 on the final word (bit_cnt <= OUT_W). Then -> DONE.
//    DONE: flush_done=1 for one cycle, then -> RUN.
//  Flush with empty buffer: RUN->FLUSH->DONE, no word emitted.
//  flush ignored outside RUN. rst at any time aborts a flush; data is lost.
//  tok_cnt increments on each in fire, wraps modulo 2^CNT_W.
// STRUCTURE
//  Package lz77_pkg: OFF_W/LEN_W/CHR_W defaults, TOK_W function,
//    state enum {RUN,FLUSH,DONE}, token struct.
//  Sub-module lz77_tok_fmt (comb): token -> {bits, tok_bits}, MSB-aligned.
//  Top: bit buffer/shifter, bit_cnt, FSM, counter.
// TESTING (defaults unless noted)
//  1 COMPACT=1: (2,3,'h41), (0,0,'h42), flush, out_ready=1
//    -> 'hA682, then 'h4200 with out_last=1; flush_done pulse; tok_cnt=2.
//  2 COMPACT=0: (2,3,'h41), flush -> single word 'h4D04, out_last=1.
//  3 out_ready=0, push full tokens: 2 accepted (bit_cnt 15, 30), in_ready=0.
//    out_data stable at first word; release -> words drain in order.
//  4 flush with bit_cnt=0 -> flush_done 2 cycles later, out_valid never 1.
//  5 rst mid-FLUSH with out_valid=1 -> outputs 0 next edge; clean restart.
//  6 CNT_W=4: 17 literals -> tok_cnt=1; random stream vs bit-level model,
//    including in/out same-cycle fire.

Source files
------------

// File: rtl/lz77_token_packer_pkg.sv
// Shared definitions for the LZ77 token packer.
//   - default field widths for offset / length / next_char
//   - tok_width(): width of an uncompacted token
//   - state_t: packer FSM states
//   - token_t: one match-finder token at the default widths
package lz77_pkg;

  localparam int unsigned OFF_W_DEF = 3;
  localparam int unsigned LEN_W_DEF = 3;
  localparam int unsigned CHR_W_DEF = 8;
  localparam int unsigned OUT_W_DEF = 16;

  function automatic int unsigned tok_width(input int unsigned off_w,
                                            input int unsigned len_w,
                                            input int unsigned chr_w);
    return off_w + len_w + chr_w;
  endfunction

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OFF_W_DEF-1:0] off;
    logic [LEN_W_DEF-1:0] len;
    logic [CHR_W_DEF-1:0] chr;
  } token_t;

endpackage

// File: rtl/lz77_tok_fmt.sv
// Combinational token formatter.
// Turns one (offset, length, next_char) token into its bitstream form,
// MSB-aligned in a MAX_T-bit field, plus the number of valid bits.
// Ports:
//   offset, length, chr : token fields from the match finder
//   bits                : encoded token, first bit at MSB, unused LSBs zero
//   tok_bits            : number of valid bits in 'bits'
module lz77_tok_fmt
  import lz77_pkg::*;
#(
  parameter int unsigned OFF_W   = OFF_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned CHR_W   = CHR_W_DEF,
  parameter int unsigned COMPACT = 1,
  parameter int unsigned MAX_T   = tok_width(OFF_W, LEN_W, CHR_W) + COMPACT,
  parameter int unsigned TW      = $clog2(MAX_T + 1)
) (
  input  logic [OFF_W-1:0] offset,
  input  logic [LEN_W-1:0] length,
  input  logic [CHR_W-1:0] chr,
  output logic [MAX_T-1:0] bits,
  output logic [TW-1:0]    tok_bits
);

  localparam int unsigned TOK_W = tok_width(OFF_W, LEN_W, CHR_W);

  if (COMPACT != 0) begin : g_compact
    // Literals drop offset/length and carry a 0 flag; matches carry a 1 flag.
    always_comb begin
      if (length != '0) begin
        bits     = {1'b1, offset, length, chr};
        tok_bits = TW'(MAX_T);
      end else begin
        bits     = {1'b0, chr, {(MAX_T - 1 - CHR_W){1'b0}}};
        tok_bits = TW'(1 + CHR_W);
      end
    end
  end else begin : g_fixed
    always_comb begin
      bits     = {offset, length, chr};
      tok_bits = TW'(TOK_W);
    end
  end

endmodule

// File: rtl/lz77_token_packer.sv
// LZ77 token packer.
// Accepts tokens over valid/ready, encodes them (optionally compacted) and
// packs the resulting bitstream MSB-first into OUT_W-bit output words.
// A flush request drains the buffer, zero-padding the final partial word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid / in_ready, in_offset, in_length, in_char : token input
//   flush       : drain request, honoured only while running
//   out_valid / out_ready, out_data, out_last          : packed word output
//   flush_done  : one-cycle pulse when a flush has completed
//   tok_cnt     : accepted tokens since reset, wrapping
module lz77_token_packer
  import lz77_pkg::*;
#(
  parameter int unsigned OFF_W   = OFF_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned CHR_W   = CHR_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned COMPACT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OFF_W-1:0] in_offset,
  input  logic [LEN_W-1:0] in_length,
  input  logic [CHR_W-1:0] in_char,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             flush_done,
  output logic [CNT_W-1:0] tok_cnt
);

  localparam int unsigned TOK_W = tok_width(OFF_W, LEN_W, CHR_W);
  localparam int unsigned MAX_T = TOK_W + COMPACT;
  localparam int unsigned BUF_W = OUT_W + MAX_T;
  localparam int unsigned CW    = $clog2(BUF_W + 1);
  localparam int unsigned TW    = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] OUT_CNT = CW'(OUT_W);

  state_t           state;
  state_t           state_next;
  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] bit_buf_next;
  logic [BUF_W-1:0] buf_shifted;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_next;
  logic [CW-1:0]    cnt_shifted;
  logic [MAX_T-1:0] tok_data;
  logic [TW-1:0]    tok_len;
  logic             in_fire;
  logic             out_fire;

  lz77_tok_fmt #(
    .OFF_W  (OFF_W),
    .LEN_W  (LEN_W),
    .CHR_W  (CHR_W),
    .COMPACT(COMPACT),
    .MAX_T  (MAX_T),
    .TW     (TW)
  ) u_fmt (
    .offset  (in_offset),
    .length  (in_length),
    .chr     (in_char),
    .bits    (tok_data),
    .tok_bits(tok_len)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // FSM next state and handshake outputs, all from registered state
  always_comb begin
    state_next = state;
    in_ready   = (state == RUN) && (bit_cnt <= OUT_CNT);
    out_valid  = (bit_cnt >= OUT_CNT) || ((state == FLUSH) && (bit_cnt != '0));
    out_last   = (state == FLUSH) && (bit_cnt != '0) && (bit_cnt <= OUT_CNT);
    flush_done = (state == DONE);
    out_data   = bit_buf[BUF_W-1 -: OUT_W];
    unique case (state)
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (bit_cnt == '0) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Bits below bit_cnt are always zero, so shifting in zeros and OR-ing new
  // tokens keeps the padding of a partial flush word free.
  always_comb begin
    buf_shifted = bit_buf;
    cnt_shifted = bit_cnt;
    if (out_fire) begin
      buf_shifted = bit_buf << OUT_W;
      cnt_shifted = (bit_cnt >= OUT_CNT) ? (bit_cnt - OUT_CNT) : '0;
    end
    bit_buf_next = buf_shifted;
    bit_cnt_next = cnt_shifted;
    if (in_fire) begin
      bit_buf_next = buf_shifted | ({tok_data, {OUT_W{1'b0}}} >> cnt_shifted);
      bit_cnt_next = cnt_shifted + CW'(tok_len);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf <= '0;
      bit_cnt <= '0;
      tok_cnt <= '0;
    end else begin
      bit_buf <= bit_buf_next;
      bit_cnt <= bit_cnt_next;
      if (in_fire) tok_cnt <= tok_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lz77_token_packer.sv
module tb_lz77_token_packer;
  import lz77_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  // compacting instance
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_last, flush_done;
  logic [2:0]  in_offset, in_length;
  logic [7:0]  in_char;
  logic [15:0] out_data;
  logic [3:0]  tok_cnt;
  // fixed-width instance
  logic        f_in_valid, f_in_ready, f_flush, f_out_valid, f_out_ready, f_out_last, f_flush_done;
  logic [2:0]  f_in_offset, f_in_length;
  logic [7:0]  f_in_char;
  logic [15:0] f_out_data;
  logic [15:0] f_tok_cnt;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

  lz77_token_packer #(.COMPACT(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_offset(in_offset), .in_length(in_length), .in_char(in_char),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .flush_done(flush_done),
    .tok_cnt(tok_cnt)
  );

  lz77_token_packer #(.COMPACT(0)) u_fix (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_offset(f_in_offset), .in_length(f_in_length), .in_char(f_in_char),
    .flush(f_flush), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_data(f_out_data), .out_last(f_out_last), .flush_done(f_flush_done),
    .tok_cnt(f_tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model: bitstream as a queue of bits --------
  typedef struct {
    logic [15:0] data;
    bit          last;
  } word_t;

  bit          mq[$];      // model bits not yet forming a full word
  word_t       expq[$];    // expected output words, oldest first
  logic [16:0] seen[$];    // {last,data} of every word the DUT emitted
  bit          run;
  int          tok_model;
  bit          prev_stall;
  logic [15:0] prev_data;

  function automatic void push_token(input logic [2:0] off, input logic [2:0] len,
                                     input logic [7:0] chr);
    logic [15:0] w;
    if (len != 0) begin
      mq.push_back(1'b1);
      for (int i = 2; i >= 0; i--) mq.push_back(off[i]);
      for (int i = 2; i >= 0; i--) mq.push_back(len[i]);
    end else begin
      mq.push_back(1'b0);
    end
    for (int i = 7; i >= 0; i--) mq.push_back(chr[i]);
    while (mq.size() >= 16) begin
      w = '0;
      for (int i = 0; i < 16; i++) w = {w[14:0], mq.pop_front()};
      expq.push_back('{data: w, last: 1'b0});
    end
  endfunction

  function automatic void finalize();
    logic [15:0] w;
    int n;
    n = mq.size();
    if (n > 0) begin
      w = '0;
      for (int i = 0; i < 16; i++) begin
        if (i < n) w = {w[14:0], mq.pop_front()};
        else       w = {w[14:0], 1'b0};
      end
      expq.push_back('{data: w, last: 1'b1});
    end else if (expq.size() > 0) begin
      expq[expq.size()-1].last = 1'b1;
    end
  endfunction

  // ---------------- monitor / scoreboard for the compacting instance ------
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      mq.delete();
      expq.delete();
      run        = 1'b1;
      tok_model  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        seen.push_back({out_last, out_data});
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word got %0h expected none", out_data);
        end else begin
          w = expq.pop_front();
          check("word_data", 32'(out_data), 32'(w.data));
          check("word_last", 32'(out_last), 32'(w.last));
        end
      end
      if (!run) check("in_ready_idle", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        push_token(in_offset, in_length, in_char);
        tok_model++;
      end
      if (flush && run) begin
        finalize();
        run = 1'b0;
      end
      if (flush_done) begin
        check("drained", 32'(expq.size()), 32'd0);
        check("done_tok_cnt", 32'(tok_cnt), 32'(tok_model % 16));
        run = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // fixed-width instance: record emitted words and completed flushes
  logic [16:0] f_seen[$];
  int          f_done = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (f_out_valid && f_out_ready) f_seen.push_back({f_out_last, f_out_data});
      if (f_flush_done) f_done++;
    end
  end

  // downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic send(input token_t t);
    bit acc = 1'b0;
    int n   = 0;
    in_valid  = 1'b1;
    in_offset = t.off;
    in_length = t.len;
    in_char   = t.chr;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 expected 1");
    end
  endtask

  task automatic do_flush();
    bit seen_done = 1'b0;
    int n = 0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    while (!seen_done && n < 500) begin
      @(negedge clk);
      seen_done = flush_done;
      @(posedge clk);
      #1;
      n++;
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout got flush_done 0 expected 1");
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    token_t t;
    rst = 1'b1;
    in_valid = 1'b0; in_offset = '0; in_length = '0; in_char = '0;
    flush = 1'b0; out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_offset = '0; f_in_length = '0; f_in_char = '0;
    f_flush = 1'b0; f_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_tok_cnt", 32'(tok_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // match + literal, then flush
    seen.delete();
    send('{off: 3'd2, len: 3'd3, chr: 8'h41});
    send('{off: 3'd0, len: 3'd0, chr: 8'h42});
    do_flush();
    check("t1_words", 32'(seen.size()), 32'd2);
    check("t1_word0", 32'(seen[0]), 32'h0A682);
    check("t1_word1", 32'(seen[1]), 32'h14200);
    check("t1_tok_cnt", 32'(tok_cnt), 32'd2);

    // fixed-width encoding
    f_in_offset = 3'd2; f_in_length = 3'd3; f_in_char = 8'h41; f_in_valid = 1'b1;
    @(negedge clk);
    check("t2_in_ready", 32'(f_in_ready), 32'd1);
    @(posedge clk);
    #1;
    f_in_valid = 1'b0;
    f_flush = 1'b1;
    @(posedge clk);
    #1;
    f_flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t2_words", 32'(f_seen.size()), 32'd1);
    check("t2_word0", 32'(f_seen[0]), 32'h14D04);
    check("t2_done", 32'(f_done), 32'd1);
    check("t2_tok_cnt", 32'(f_tok_cnt), 32'd1);

    // backpressure: two full tokens fit, the third waits
    rmode = 2;
    @(posedge clk);
    #1;
    send('{off: 3'd2, len: 3'd3, chr: 8'h41});
    send('{off: 3'd5, len: 3'd7, chr: 8'hC3});
    in_valid = 1'b1; in_offset = 3'd1; in_length = 3'd1; in_char = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_out_data", 32'(out_data), 32'hA683);
    end
    @(posedge clk);
    #1;
    rmode = 0;
    send('{off: 3'd1, len: 3'd1, chr: 8'h11});
    do_flush();

    // flush with empty buffer
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("t4_done_early", 32'(flush_done), 32'd0);
    check("t4_valid_a", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_done", 32'(flush_done), 32'd1);
    check("t4_valid_b", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_done_late", 32'(flush_done), 32'd0);
    @(posedge clk);
    #1;

    // reset in the middle of a flush
    rmode = 2;
    @(posedge clk);
    #1;
    send('{off: 3'd3, len: 3'd2, chr: 8'h99});
    send('{off: 3'd4, len: 3'd5, chr: 8'h66});
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("t5_valid_before", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd0);
    check("t5_out_last", 32'(out_last), 32'd0);
    check("t5_flush_done", 32'(flush_done), 32'd0);
    check("t5_tok_cnt", 32'(tok_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rmode = 0;
    send('{off: 3'd0, len: 3'd0, chr: 8'h5A});
    do_flush();
    check("t5_restart_cnt", 32'(tok_cnt), 32'd1);

    // counter wrap, then a random stream with random backpressure
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      t.off = 3'($urandom);
      t.len = 3'd0;
      t.chr = 8'($urandom);
      send(t);
    end
    check("t6_wrap", 32'(tok_cnt), 32'd1);
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      t.off = 3'($urandom);
      t.len = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      t.chr = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(t);
      if (i % 50 == 49) do_flush();
    end
    do_flush();
    check("t6_tok_cnt", 32'(tok_cnt), 32'((17 + 300) % 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
